// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: N-to-1 Sysbus request arbiter with tag-based response demux.
// Grants one master at a time and holds the grant for a whole multi-beat
// transaction. The granted port ID is prepended to the outgoing request tag,
// and responses are routed back to a port by the ID field of the response tag.
// Optional build macro SYSBUS_ARB_FIXED_PRIO_EN: when defined, the lowest-numbered
// requesting port always wins and no round-robin pointer exists; when undefined
// (default), selection is round-robin starting at the port after the last grant.
module sysbus_arbiter #(
    parameter int  DATA_WIDTH = 64,
    parameter int  TAG_WIDTH  = 13,
    parameter int  NUM_PORTS  = 4,
    localparam int ID_W       = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    // master-side request channel
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_req,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0]  p_reqtag,
    input  logic [NUM_PORTS-1:0]            p_reqcyc,
    output logic [NUM_PORTS-1:0]            p_reqack,
    // master-side response channel
    output logic [DATA_WIDTH-1:0]           p_resp,
    output logic [TAG_WIDTH-1:0]            p_resptag,
    output logic [NUM_PORTS-1:0]            p_respcyc,
    input  logic [NUM_PORTS-1:0]            p_respack,
    // memory-side request channel
    output logic [DATA_WIDTH-1:0]           bus_req,
    output logic [TAG_WIDTH+ID_W-1:0]       bus_reqtag,
    output logic                            bus_reqcyc,
    input  logic                            bus_reqack,
    // memory-side response channel
    input  logic [DATA_WIDTH-1:0]           bus_resp,
    input  logic [TAG_WIDTH+ID_W-1:0]       bus_resptag,
    input  logic                            bus_respcyc,
    output logic                            bus_respack,
    // sticky error: a response addressed a port that does not exist
    output logic                            tag_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       pick_id;

    logic [DATA_WIDTH-1:0] sel_req;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic                  sel_cyc;

    logic [ID_W-1:0]       dest;
    logic                  dest_ok;

`ifndef SYSBUS_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]       rr_ptr;

    // Round-robin pick: first requester at or after start, wrapping at NUM_PORTS.
    // The extra index bit keeps start+i from overflowing before the wrap.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [ID_W-1:0]      start);
        logic [ID_W-1:0] sel;
        logic [ID_W:0]   idx;
        logic            found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, start} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_PORTS)) begin
                idx = idx - (ID_W+1)'(NUM_PORTS);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Port following id, wrapping NUM_PORTS-1 back to 0.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (id == ID_W'(NUM_PORTS - 1)) begin
            nxt = '0;
        end else begin
            nxt = id + 1'b1;
        end
        return nxt;
    endfunction
`else
    // Fixed priority pick: lowest-numbered requester wins.
    function automatic logic [ID_W-1:0] fixed_pick(input logic [NUM_PORTS-1:0] req);
        logic [ID_W-1:0] sel;
        sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = ID_W'(i);
            end
        end
        return sel;
    endfunction
`endif

    // Choose the next port to grant from the current request vector.
    always_comb begin
        pick_id = '0;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
        pick_id = rr_pick(p_reqcyc, rr_ptr);
`else
        pick_id = fixed_pick(p_reqcyc);
`endif
    end

    // Select the granted port's request fields; no buffering, pure mux.
    always_comb begin
        sel_req = '0;
        sel_tag = '0;
        sel_cyc = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_req = p_req[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag = p_reqtag[i*TAG_WIDTH +: TAG_WIDTH];
                sel_cyc = p_reqcyc[i];
            end
        end
    end

    // Drive the memory-side request and the per-port beat acknowledge.
    // bus_reqcyc is forced low outside BUSY, so a reset drops it at once.
    always_comb begin
        bus_req    = sel_req;
        bus_reqtag = {grant_id, sel_tag};
        bus_reqcyc = (state == BUSY) && sel_cyc;
        p_reqack   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p_reqack[i] = (state == BUSY) && bus_reqack && (grant_id == ID_W'(i));
        end
    end

    // Grant FSM: IDLE picks a requester, BUSY holds it until its reqcyc drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|p_reqcyc) begin
                        grant_id <= pick_id;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        state  <= IDLE;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
                        rr_ptr <= wrap_inc(grant_id);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response demux by the destination ID in the top tag bits; independent of
    // the request grant. An ID with no matching port is drained (ack held high).
    always_comb begin
        dest        = bus_resptag[TAG_WIDTH +: ID_W];
        dest_ok     = 1'b0;
        p_respcyc   = '0;
        bus_respack = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dest == ID_W'(i)) begin
                dest_ok      = 1'b1;
                p_respcyc[i] = bus_respcyc;
                bus_respack  = p_respack[i];
            end
        end
        p_resptag = bus_resptag[TAG_WIDTH-1:0];
        p_resp    = bus_resp;
    end

    // Remember any response beat aimed at a nonexistent port until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_err <= 1'b0;
        end else if (bus_respcyc && !dest_ok) begin
            tag_err <= 1'b1;
        end
    end

endmodule
